// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    // Default number of byte-stream requesters sharing one transmitter.
    localparam int DEF_NUM_REQ = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a request
        ST_SEND    = 2'd1,  // owner may hand over one byte
        ST_WAIT_TX = 2'd2,  // byte handed over, transmitter still busy
        ST_GAP     = 2'd3   // enforced idle time after a frame
    } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: searches upward from ptr_i+1 with
// wrap-around and returns the first active request as one-hot and index.
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    logic [IDW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        any_o = |req_i;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDW'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule : uart_rr_arb

// File: rtl/uart_tx_arb.sv
// Arbitrates several byte-stream requesters onto one UART transmitter.
// A grant is held for a whole frame, optional idle gap after each frame,
// and a mid-frame starvation timeout releases a stalled owner.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cfg_en_i,
    input  logic [7:0]             cfg_gap_i,
    input  logic [7:0]             cfg_tmo_i,
    input  logic                   flow_stop_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic                   tx_busy_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   tmo_o
);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic                 last_q, last_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_q, tmo_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;

    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;
    logic                 release_grant;

    uart_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Per-owner view of the request bundle.
    always_comb begin
        own_valid = req_valid_i[grant_id_q];
        own_last  = req_last_i[grant_id_q];
        own_data  = req_data_i[int'(grant_id_q)*8 +: 8];
    end

    // Next-state logic and SEND-phase outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        rr_d          = rr_q;
        last_d        = last_q;
        gap_cnt_d     = gap_cnt_q;
        tmo_cnt_d     = '0;
        tmo_d         = 1'b0;
        release_grant = 1'b0;
        tx_valid_o    = 1'b0;
        tx_data_o     = 8'h00;
        req_ready_o   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && !flow_stop_i && arb_any) begin
                    grant_d    = arb_gnt;
                    grant_id_d = arb_idx;
                    rr_d       = arb_idx;
                    last_d     = 1'b0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                tx_valid_o  = own_valid & ~flow_stop_i;
                tx_data_o   = own_data;
                req_ready_o = grant_q & {NUM_REQ{tx_ready_i & ~flow_stop_i}};
                tmo_cnt_d   = tmo_cnt_q;
                if (flow_stop_i) begin
                    // Paused: grant and starvation count are both frozen.
                    tmo_cnt_d = tmo_cnt_q;
                end else if (own_valid) begin
                    tmo_cnt_d = '0;
                    if (tx_ready_i) begin
                        last_d  = own_last;
                        state_d = ST_WAIT_TX;
                    end
                end else if (cfg_tmo_i != 8'd0) begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_d == cfg_tmo_i) begin
                        tmo_d         = 1'b1;
                        tmo_cnt_d     = '0;
                        release_grant = 1'b1;
                    end
                end
            end

            ST_WAIT_TX: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        release_grant = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // End of frame or starvation: drop the owner, then idle gap if configured.
        if (release_grant) begin
            grant_d    = '0;
            grant_id_d = '0;
            last_d     = 1'b0;
            gap_cnt_d  = cfg_gap_i;
            state_d    = (cfg_gap_i == 8'd0) ? ST_IDLE : ST_GAP;
        end

        // Disable wins over everything except the round-robin pointer.
        if (!cfg_en_i) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            last_d     = 1'b0;
            gap_cnt_d  = '0;
            tmo_cnt_d  = '0;
            tmo_d      = 1'b0;
            rr_d       = rr_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of the others.
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_q       <= IDW'(NUM_REQ - 1);
            last_q     <= 1'b0;
            gap_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign tmo_o      = tmo_q;

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a per-cycle vector table for round-robin
// and frame lock, plus hand sequences for gap, timeout, flow stop, disable
// and mid-frame reset.
module tb_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int LIM     = 200;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i;
    logic                 cfg_en_i;
    logic [7:0]           cfg_gap_i;
    logic [7:0]           cfg_tmo_i;
    logic                 flow_stop_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic                 tx_busy_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic [IDW-1:0]       grant_id_o;
    logic                 tmo_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_gap_i   (cfg_gap_i),
        .cfg_tmo_i   (cfg_tmo_i),
        .flow_stop_i (flow_stop_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_busy_i   (tx_busy_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .tmo_o       (tmo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       en, flow, rdy, busy;
        logic [3:0] valid, last;
        logic       e_tv;
        logic [7:0] e_data;
        logic [3:0] e_rdy, e_gnt;
        logic [1:0] e_gid;
        logic       e_tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, flow, rdy, busy, input logic [3:0] valid, last,
                       input logic tv, input logic [7:0] data, input logic [3:0] rdy_o, gnt,
                       input logic [1:0] gid, input logic tmo);
        vec_t v;
        v.en = en; v.flow = flow; v.rdy = rdy; v.busy = busy;
        v.valid = valid; v.last = last;
        v.e_tv = tv; v.e_data = data; v.e_rdy = rdy_o; v.e_gnt = gnt;
        v.e_gid = gid; v.e_tmo = tmo;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, compare outputs mid-cycle, advance past the edge.
    task automatic apply(input vec_t v, input int i);
        cfg_en_i = v.en; flow_stop_i = v.flow; tx_ready_i = v.rdy; tx_busy_i = v.busy;
        req_valid_i = v.valid; req_last_i = v.last;
        @(negedge clk_i);
        check($sformatf("vec%0d tx_valid", i), 32'(tx_valid_o), 32'(v.e_tv));
        check($sformatf("vec%0d tx_data", i), 32'(tx_data_o), 32'(v.e_data));
        check($sformatf("vec%0d req_ready", i), 32'(req_ready_o), 32'(v.e_rdy));
        check($sformatf("vec%0d grant", i), 32'(grant_o), 32'(v.e_gnt));
        check($sformatf("vec%0d grant_id", i), 32'(grant_id_o), 32'(v.e_gid));
        check($sformatf("vec%0d tmo", i), 32'(tmo_o), 32'(v.e_tmo));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        cfg_en_i = 1'b1; cfg_gap_i = 8'd0; cfg_tmo_i = 8'd0; flow_stop_i = 1'b0;
        req_valid_i = '0; req_last_i = '0; tx_ready_i = 1'b1; tx_busy_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset grant", 32'(grant_o), 32'h0);
        check("reset grant_id", 32'(grant_id_o), 32'h0);
        check("reset tx_valid", 32'(tx_valid_o), 32'h0);
        check("reset tx_data", 32'(tx_data_o), 32'h0);
        check("reset req_ready", 32'(req_ready_o), 32'h0);
        check("reset tmo", 32'(tmo_o), 32'h0);
        rst_n_i = 1'b1;
    endtask

    // From a negedge, count negedge samples until (grant_o != 0) == want.
    task automatic count_until(input bit want, output int n);
        n = 0;
        while (((grant_o != '0) != want) && n < LIM) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Round robin with single-byte frames, no gap: owners 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            add(1, 0, 1, 0, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
            add(1, 0, 1, 0, 4'hF, 4'hF, 1, 8'(8'hA0 + g), 4'(1 << g), 4'(1 << g), 2'(g), 0);
            add(1, 0, 1, 0, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'(1 << g), 2'(g), 0);
        end
        // Frame lock: requester 1 sends three bytes while requester 2 waits.
        add(1, 0, 1, 0, 4'h6, 4'h4, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
        add(1, 0, 0, 0, 4'h6, 4'h4, 1, 8'hA1, 4'h0, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h4, 1, 8'hA1, 4'h2, 4'h2, 2'd1, 0);
        add(1, 0, 1, 1, 4'h6, 4'h4, 0, 8'h00, 4'h0, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h4, 0, 8'h00, 4'h0, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h4, 1, 8'hA1, 4'h2, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h4, 0, 8'h00, 4'h0, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h6, 1, 8'hA1, 4'h2, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h6, 0, 8'h00, 4'h0, 4'h2, 2'd1, 0);
        add(1, 0, 1, 0, 4'h6, 4'h6, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
        add(1, 0, 1, 0, 4'h6, 4'h6, 1, 8'hA2, 4'h4, 4'h4, 2'd2, 0);
        add(1, 0, 1, 0, 4'h6, 4'h6, 0, 8'h00, 4'h0, 4'h4, 2'd2, 0);
        // Flow stop in IDLE blocks a new grant; next search starts after 2.
        add(1, 1, 1, 0, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
        add(1, 1, 1, 0, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
        add(1, 0, 1, 0, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'h0, 2'd0, 0);
        add(1, 0, 1, 0, 4'hF, 4'hF, 1, 8'hA3, 4'h8, 4'h8, 2'd3, 0);

        do_reset();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Gap of 5: five GAP cycles plus one IDLE cycle without a grant.
        do_reset();
        cfg_gap_i = 8'd5; req_valid_i = 4'b0001; req_last_i = 4'b0001;
        count_until(1'b1, n);
        check("gap first grant", 32'(grant_o), 32'h1);
        count_until(1'b0, n);
        count_until(1'b1, n);
        check("gap5 idle cycles", 32'(n), 32'd6);
        cfg_gap_i = 8'd0;
        count_until(1'b0, n);
        count_until(1'b1, n);
        check("gap0 idle cycles", 32'(n), 32'd1);

        // Timeout of 10 after the owner drops valid mid-frame.
        do_reset();
        cfg_tmo_i = 8'd10; req_valid_i = 4'b0011; req_last_i = 4'b0010;
        count_until(1'b1, n);
        check("tmo owner", 32'(grant_o), 32'h1);
        @(negedge clk_i);
        req_valid_i = 4'b0010;
        check("tmo held in wait", 32'(grant_o), 32'h1);
        @(negedge clk_i);
        n = 0; bad = 0;
        while (!tmo_o && n < 50) begin
            if (grant_o != 4'b0001 || tx_valid_o) bad++;
            n++;
            @(negedge clk_i);
        end
        check("tmo latency", 32'(n), 32'd10);
        check("tmo grant held before", 32'(bad), 32'd0);
        check("tmo pulse", 32'(tmo_o), 32'h1);
        check("tmo grant cleared", 32'(grant_o), 32'h0);
        @(negedge clk_i);
        check("tmo single pulse", 32'(tmo_o), 32'h0);
        check("tmo next owner", 32'(grant_o), 32'h2);
        check("tmo next owner id", 32'(grant_id_o), 32'd1);

        // Timeout value 0 never releases a starving owner.
        do_reset();
        req_valid_i = 4'b0001; req_last_i = 4'b0000;
        count_until(1'b1, n);
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        bad = 0;
        repeat (300) begin
            @(negedge clk_i);
            if (tmo_o || grant_o != 4'b0001) bad++;
        end
        check("tmo0 disabled", 32'(bad), 32'd0);

        // Flow stop for 20 cycles in SEND holds the byte and the grant.
        do_reset();
        cfg_tmo_i = 8'd10; req_valid_i = 4'b0001; req_last_i = 4'b0001;
        count_until(1'b1, n);
        flow_stop_i = 1'b1;
        #1;
        check("flow tx_valid off", 32'(tx_valid_o), 32'h0);
        check("flow ready off", 32'(req_ready_o), 32'h0);
        bad = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (tx_valid_o || req_ready_o != '0 || grant_o != 4'b0001 || tmo_o) bad++;
        end
        check("flow hold", 32'(bad), 32'd0);
        flow_stop_i = 1'b0;
        #1;
        check("flow resume valid", 32'(tx_valid_o), 32'h1);
        check("flow resume data", 32'(tx_data_o), 32'hA0);
        check("flow resume ready", 32'(req_ready_o), 32'h1);
        @(negedge clk_i);
        check("flow sent grant", 32'(grant_o), 32'h1);
        check("flow sent tx_valid", 32'(tx_valid_o), 32'h0);
        @(negedge clk_i);
        check("flow frame done", 32'(grant_o), 32'h0);

        // Disable during WAIT_TX; pointer survives so requester 1 wins next.
        do_reset();
        req_valid_i = 4'b0011; req_last_i = 4'b0011; tx_busy_i = 1'b1;
        count_until(1'b1, n);
        check("dis first owner", 32'(grant_o), 32'h1);
        @(negedge clk_i);
        check("dis in wait", 32'(grant_o), 32'h1);
        cfg_en_i = 1'b0;
        @(negedge clk_i);
        check("dis grant cleared", 32'(grant_o), 32'h0);
        check("dis grant_id cleared", 32'(grant_id_o), 32'd0);
        check("dis tx_valid", 32'(tx_valid_o), 32'h0);
        @(negedge clk_i);
        check("dis no grant", 32'(grant_o), 32'h0);
        tx_busy_i = 1'b0; cfg_en_i = 1'b1;
        @(negedge clk_i);
        check("dis reenable owner", 32'(grant_o), 32'h2);
        check("dis reenable id", 32'(grant_id_o), 32'd1);

        // Reset mid-frame abandons the frame and restores priority to 0.
        do_reset();
        req_valid_i = 4'b0010; req_last_i = 4'b0000; tx_busy_i = 1'b1;
        count_until(1'b1, n);
        @(negedge clk_i);
        check("rst mid owner", 32'(grant_o), 32'h2);
        req_valid_i = 4'b0011;
        rst_n_i = 1'b0;
        #1;
        check("rst mid grant", 32'(grant_o), 32'h0);
        check("rst mid tx_valid", 32'(tx_valid_o), 32'h0);
        check("rst mid tx_data", 32'(tx_data_o), 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tx_busy_i = 1'b0;
        @(negedge clk_i);
        check("rst after owner", 32'(grant_o), 32'h1);
        check("rst after id", 32'(grant_id_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arb

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter IDW, default $clog2(NUM_REQ), meaning the grant index width.
REQ-003 clk_i  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 cfg_en_i  input  1  arbiter enable.
REQ-006 cfg_gap_i  input  8  idle cycles inserted after each frame's last byte.
REQ-007 cfg_tmo_i  input  8  mid-frame starvation timeout in cycles; 0 disables it.
REQ-008 flow_stop_i  input  1  remote not ready (CTS deasserted); 1 pauses new bytes.
REQ-009 req_data_i  input  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k].
REQ-010 req_valid_i / req_last_i  input  NUM_REQ each  per-requester valid and last-byte-of-frame flags.
REQ-011 req_ready_o  output  NUM_REQ  per-requester accept.
REQ-012 tx_data_o / tx_valid_o  output  8 / 1  byte and valid to the transmitter.
REQ-013 tx_ready_i / tx_busy_i  input  1 each  transmitter ready and busy.
REQ-014 grant_o / grant_id_o  output  NUM_REQ / IDW  one-hot owner and its index.
REQ-015 tmo_o  output  1  single-cycle pulse on timeout release.

Function
REQ-016 A transfer SHALL occur on a cycle where valid and ready are both 1; at most one requester SHALL see req_ready_o=1 per cycle.
REQ-017 The FSM SHALL have four states: IDLE, SEND, WAIT_TX and GAP.
REQ-018 IDLE: if cfg_en_i=1, flow_stop_i=0 and any req_valid_i=1, the block SHALL latch a round-robin winner into grant_o/grant_id_o and go to SEND next cycle.
REQ-019 Round-robin SHALL search from index rr_q+1 upward with wrap-around and SHALL update rr_q to the winner on grant.
REQ-020 SEND outputs SHALL be: tx_valid_o = req_valid_i[g] & ~flow_stop_i; tx_data_o = the granted byte; req_ready_o[g] = tx_ready_i & ~flow_stop_i.
REQ-021 On a SEND handshake the block SHALL capture req_last_i[g] and go to WAIT_TX.
REQ-022 WAIT_TX SHALL stay until tx_busy_i=0, then go as follows:
  - last byte and cfg_gap_i=0: to IDLE, grant cleared;
  - last byte and cfg_gap_i>0: to GAP, grant cleared;
  - otherwise: to SEND, grant held (frame lock).
REQ-023 GAP SHALL load a counter with cfg_gap_i, decrement it each cycle, and go to IDLE the cycle after it reaches 1, giving exactly cfg_gap_i GAP cycles.
REQ-024 Timeout SHALL apply in SEND while req_valid_i[g]=0 and cfg_tmo_i≠0:
  - an 8-bit counter SHALL increment each such cycle and clear on req_valid_i[g]=1;
  - at count==cfg_tmo_i the block SHALL pulse tmo_o, clear the grant and go to GAP (or to IDLE if cfg_gap_i=0).
REQ-025 flow_stop_i SHALL pause SEND without releasing the grant and without advancing the timeout counter.
REQ-026 cfg_en_i=0 SHALL force the following next cycle, from any state:
  - state IDLE;
  - grant, counters and outputs cleared;
  - rr_q kept.
REQ-027 Outside SEND, tx_valid_o and all req_ready_o bits SHALL be 0.
REQ-028 grant_id_o SHALL always equal the index of the set bit of grant_o, and SHALL be 0 when grant_o=0.

Reset
REQ-029 Reset SHALL set state IDLE and clear grant_o, grant_id_o, tx_valid_o, req_ready_o, tmo_o and all counters.
REQ-030 Reset SHALL set tx_data_o to 8'h00 and rr_q to NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no byte SHALL be replayed after release.

Structure
REQ-032 The FSM state enum and the default NUM_REQ constant SHALL live in the shared package uart_pkg.
REQ-033 The round-robin picker SHALL be a combinational sub-module uart_rr_arb (inputs: request vector, pointer; outputs: one-hot grant, index, any-valid).

Verification
REQ-034 Round-robin: all four requesters valid with single-byte frames, cfg_gap_i=0 -> grant order 0,1,2,3,0.
REQ-035 Frame lock: requester 1 sends 3 bytes (last on the third) while requester 2 is valid -> requester 1 keeps the grant for all 3 bytes, then requester 2 is granted.
REQ-036 Gap: cfg_gap_i=5 -> exactly 5 GAP cycles between the last byte's WAIT_TX exit and the next grant.
REQ-037 Timeout: cfg_tmo_i=10 and the owner drops valid mid-frame -> tmo_o pulses once 10 cycles after the drop, and the grant passes to the next requester.
REQ-038 Flow stop: flow_stop_i=1 for 20 cycles in SEND -> tx_valid_o=0, grant held and no tmo_o; after release the byte is sent.
REQ-039 Disable: cfg_en_i=0 during WAIT_TX -> IDLE next cycle with grant_o=0, and requester 1 is granted first after re-enable if rr_q=0.
